// File: rtl/split_bus_arbiter.sv
// Central bus arbiter: grants init0, init1 or the split target. It tracks one outstanding split
// and forces release of a stuck tenure after TIMEOUT_CYCLES busy cycles.
//   state  | meaning
//   S_IDLE | bus free; arbitrate on this cycle's requests, and the winner owns the bus from the next edge
//   S_BUSY | a tenure is in progress; wait for done, split, abandon or timeout
module split_bus_arbiter #(
   parameter int unsigned TIMEOUT_CYCLES = 64
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       init0_req,
   input  logic       init1_req,
   input  logic       split_req,
   input  logic       txn_done,
   input  logic       split_ack,
   output logic       init0_grant,
   output logic       init1_grant,
   output logic       split_grant,
   output logic [1:0] owner,
   output logic       split_pending,
   output logic       split_owner,
   output logic       timeout,
   output logic       split_err
);

   localparam int unsigned CNT_W = (TIMEOUT_CYCLES == 0) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYCLES);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1);

   localparam logic [1:0] OWN_NONE  = 2'd0;
   localparam logic [1:0] OWN_I0    = 2'd1;
   localparam logic [1:0] OWN_I1    = 2'd2;
   localparam logic [1:0] OWN_SPLIT = 2'd3;

   typedef enum logic {S_IDLE, S_BUSY} state_t;

   state_t           state_q, state_d;
   logic [1:0]       owner_q, owner_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             pend_q, pend_d;
   logic             sown_q, sown_d;
   logic             last_q, last_d;
   logic             timeout_q, timeout_d;
   logic             err_q, err_d;
   logic             g0_q, g0_d, g1_q, g1_d, gs_q, gs_d;

   logic             elig0, elig1, owner_req, to_hit, rel;

   always_comb begin
      state_d   = state_q;
      owner_d   = owner_q;
      cnt_d     = cnt_q;
      pend_d    = pend_q;
      sown_d    = sown_q;
      last_d    = last_q;
      timeout_d = 1'b0;
      err_d     = 1'b0;
      elig0     = init0_req && !(pend_q && !sown_q);
      elig1     = init1_req && !(pend_q && sown_q);
      owner_req = 1'b0;
      to_hit    = 1'b0;
      rel       = 1'b0;

      case (state_q)
         S_IDLE: begin
            // Returning split data beats fresh initiator traffic
            if (split_req && pend_q) begin
               owner_d = OWN_SPLIT;
            end else if (elig0 && (!elig1 || last_q)) begin
               owner_d = OWN_I0;
               last_d  = 1'b0;
            end else if (elig1) begin
               owner_d = OWN_I1;
               last_d  = 1'b1;
            end
            if (owner_d != OWN_NONE) begin
               state_d = S_BUSY;
               cnt_d   = '0;
            end
         end
         S_BUSY: begin
            case (owner_q)
               OWN_I0:  owner_req = init0_req;
               OWN_I1:  owner_req = init1_req;
               default: owner_req = split_req;
            endcase
            to_hit = (TIMEOUT_CYCLES != 0) && (cnt_q == CNT_LAST);
            if (cnt_q != CNT_MAX) cnt_d = cnt_q + 1'b1;
            rel = 1'b1;
            if (txn_done || (split_ack && owner_q == OWN_SPLIT)) begin
               if (owner_q == OWN_SPLIT) pend_d = 1'b0;
            end else if (split_ack) begin
               if (pend_q) begin
                  err_d = 1'b1;
               end else begin
                  pend_d = 1'b1;
                  sown_d = (owner_q == OWN_I1);
               end
            end else if (!owner_req) begin
               rel = 1'b1;
            end else if (to_hit) begin
               timeout_d = 1'b1;
               if (owner_q == OWN_SPLIT) pend_d = 1'b0;
            end else begin
               rel = 1'b0;
            end
            if (rel) begin
               state_d = S_IDLE;
               owner_d = OWN_NONE;
            end
         end
         default: begin
            state_d = S_IDLE;
            owner_d = OWN_NONE;
         end
      endcase

      g0_d = (owner_d == OWN_I0);
      g1_d = (owner_d == OWN_I1);
      gs_d = (owner_d == OWN_SPLIT);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= S_IDLE;
         owner_q   <= OWN_NONE;
         cnt_q     <= '0;
         pend_q    <= 1'b0;
         sown_q    <= 1'b0;
         last_q    <= 1'b1;
         timeout_q <= 1'b0;
         err_q     <= 1'b0;
         g0_q      <= 1'b0;
         g1_q      <= 1'b0;
         gs_q      <= 1'b0;
      end else begin
         state_q   <= state_d;
         owner_q   <= owner_d;
         cnt_q     <= cnt_d;
         pend_q    <= pend_d;
         sown_q    <= sown_d;
         last_q    <= last_d;
         timeout_q <= timeout_d;
         err_q     <= err_d;
         g0_q      <= g0_d;
         g1_q      <= g1_d;
         gs_q      <= gs_d;
      end
   end

   assign init0_grant   = g0_q;
   assign init1_grant   = g1_q;
   assign split_grant   = gs_q;
   assign owner         = owner_q;
   assign split_pending = pend_q;
   assign split_owner   = sown_q;
   assign timeout       = timeout_q;
   assign split_err     = err_q;

endmodule

// File: tb/tb_split_bus_arbiter.sv
// Directed bench for split_bus_arbiter (TIMEOUT_CYCLES=8); expected output vectors are hand-derived.
module tb_split_bus_arbiter;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       init0_req = 1'b0, init1_req = 1'b0, split_req = 1'b0;
   logic       txn_done = 1'b0, split_ack = 1'b0;
   logic       init0_grant, init1_grant, split_grant;
   logic [1:0] owner;
   logic       split_pending, split_owner, timeout, split_err;

   int vectors = 0;
   int errs = 0;

   split_bus_arbiter #(.TIMEOUT_CYCLES(8)) dut (
      .clk(clk), .rst_n(rst_n),
      .init0_req(init0_req), .init1_req(init1_req), .split_req(split_req),
      .txn_done(txn_done), .split_ack(split_ack),
      .init0_grant(init0_grant), .init1_grant(init1_grant), .split_grant(split_grant),
      .owner(owner), .split_pending(split_pending), .split_owner(split_owner),
      .timeout(timeout), .split_err(split_err)
   );

   always #5 clk = ~clk;

   // Packed expectation: {g0, g1, gs, owner[1:0], pending, split_owner, timeout, split_err}
   function automatic logic [8:0] ex(input logic [1:0] own, input logic pend, input logic sown,
                                     input logic to, input logic err);
      return {own == 2'd1, own == 2'd2, own == 2'd3, own, pend, sown, to, err};
   endfunction

   task automatic chk(input string tag, input logic [8:0] exp);
      logic [8:0] obs;
      obs = {init0_grant, init1_grant, split_grant, owner, split_pending, split_owner, timeout, split_err};
      vectors++;
      assert (obs === exp) else begin
         errs++;
         $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic pulse_done();
      txn_done = 1'b1;
      step();
      txn_done = 1'b0;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      #2;
      chk("reset_async", ex(0, 0, 0, 0, 0));
      rst_n = 1'b1;
      step();
   endtask

   initial begin
      #3;
      chk("reset_state", ex(0, 0, 0, 0, 0));
      rst_n = 1'b1;
      step();

      // Single init0 tenure
      init0_req = 1'b1;
      step();
      chk("t1_grant", ex(1, 0, 0, 0, 0));
      step(); step(); step();
      chk("t1_hold", ex(1, 0, 0, 0, 0));
      txn_done = 1'b1;
      step();
      txn_done = 1'b0;
      init0_req = 1'b0;
      chk("t1_release", ex(0, 0, 0, 0, 0));
      step();
      chk("t1_idle", ex(0, 0, 0, 0, 0));

      // Round-robin from reset
      do_reset();
      init0_req = 1'b1;
      init1_req = 1'b1;
      step();
      chk("rr_first_i0", ex(1, 0, 0, 0, 0));
      pulse_done();
      chk("rr_gap1", ex(0, 0, 0, 0, 0));
      step();
      chk("rr_second_i1", ex(2, 0, 0, 0, 0));
      pulse_done();
      chk("rr_gap2", ex(0, 0, 0, 0, 0));
      step();
      chk("rr_third_i0", ex(1, 0, 0, 0, 0));
      txn_done = 1'b1;
      init0_req = 1'b0;
      init1_req = 1'b0;
      step();
      txn_done = 1'b0;
      chk("rr_end", ex(0, 0, 0, 0, 0));

      // Split flow: init0 parked, init1 served, split data return
      init0_req = 1'b1;
      step();
      chk("sp_i0_grant", ex(1, 0, 0, 0, 0));
      split_ack = 1'b1;
      step();
      split_ack = 1'b0;
      chk("sp_recorded", ex(0, 1, 0, 0, 0));
      step();
      chk("sp_i0_parked", ex(0, 1, 0, 0, 0));
      init1_req = 1'b1;
      step();
      chk("sp_i1_served", ex(2, 1, 0, 0, 0));
      txn_done = 1'b1;
      init1_req = 1'b0;
      step();
      txn_done = 1'b0;
      chk("sp_i1_done", ex(0, 1, 0, 0, 0));
      split_req = 1'b1;
      step();
      chk("sp_split_grant", ex(3, 1, 0, 0, 0));
      txn_done = 1'b1;
      split_req = 1'b0;
      step();
      txn_done = 1'b0;
      chk("sp_cleared", ex(0, 0, 0, 0, 0));
      step();
      chk("sp_i0_regrant", ex(1, 0, 0, 0, 0));
      txn_done = 1'b1;
      init0_req = 1'b0;
      step();
      txn_done = 1'b0;

      // split_req beats init1_req while split pending
      init0_req = 1'b1;
      step();
      split_ack = 1'b1;
      step();
      split_ack = 1'b0;
      init0_req = 1'b0;
      chk("pri_pending", ex(0, 1, 0, 0, 0));
      split_req = 1'b1;
      init1_req = 1'b1;
      step();
      chk("pri_split_wins", ex(3, 1, 0, 0, 0));
      txn_done = 1'b1;
      split_req = 1'b0;
      step();
      txn_done = 1'b0;
      chk("pri_split_done", ex(0, 0, 0, 0, 0));

      // Timeout of init1 tenure after exactly 8 granted cycles
      step();
      chk("to_grant", ex(2, 0, 0, 0, 0));
      for (int i = 0; i < 7; i++) step();
      chk("to_cycle8_still", ex(2, 0, 0, 0, 0));
      step();
      chk("to_fired", ex(0, 0, 0, 1, 0));
      init1_req = 1'b0;
      step();
      chk("to_pulse_end", ex(0, 0, 0, 0, 0));

      // split_err: split_ack on init1 while init0's split outstanding
      init0_req = 1'b1;
      step();
      split_ack = 1'b1;
      step();
      split_ack = 1'b0;
      init1_req = 1'b1;
      step();
      chk("err_i1_grant", ex(2, 1, 0, 0, 0));
      split_ack = 1'b1;
      step();
      split_ack = 1'b0;
      chk("err_pulse", ex(0, 1, 0, 0, 1));
      step();
      chk("err_i1_regrant", ex(2, 1, 0, 0, 0));
      txn_done = 1'b1;
      split_ack = 1'b1;
      init1_req = 1'b0;
      step();
      txn_done = 1'b0;
      split_ack = 1'b0;
      chk("both_pending_noerr", ex(0, 1, 0, 0, 0));
      split_req = 1'b1;
      step();
      chk("err_split_ret", ex(3, 1, 0, 0, 0));
      txn_done = 1'b1;
      split_req = 1'b0;
      step();
      txn_done = 1'b0;
      step();
      chk("both_i0_grant", ex(1, 0, 0, 0, 0));
      txn_done = 1'b1;
      split_ack = 1'b1;
      init0_req = 1'b0;
      step();
      txn_done = 1'b0;
      split_ack = 1'b0;
      chk("both_no_split", ex(0, 0, 0, 0, 0));

      // Async reset mid-tenure with split pending
      init1_req = 1'b1;
      step();
      split_ack = 1'b1;
      step();
      split_ack = 1'b0;
      init1_req = 1'b1;
      init0_req = 1'b1;
      step();
      chk("rst_pre", ex(1, 1, 1, 0, 0));
      init0_req = 1'b0;
      do_reset();
      chk("rst_after_i1", ex(2, 0, 0, 0, 0));

      $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
      $finish;
   end

endmodule

// File: doc/split_bus_arbiter.md
# split_bus_arbiter

Central arbiter for the serial bus: shares the single address/data path between initiator 0, initiator 1 and the split target's data-return request. It tracks one outstanding split transaction, parks the split initiator until the split target returns data, and forces release of stuck tenures via a timeout. It drives grant lines and an owner code that the bus muxes use for routing.

## Interface
- TIMEOUT_CYCLES, 64, max cycles a tenure may hold the bus before forced release; 0 disables the timeout
- clk  in  1  clock, rising edge
- rst_n  in  1  reset, asynchronous, active-low
- init0_req  in  1  initiator 0 bus request, level, held until tenure ends
- init1_req  in  1  initiator 1 bus request
- split_req  in  1  split target requests bus to return split read data
- txn_done  in  1  one-cycle pulse: current tenure completed (target ack seen by bus)
- split_ack  in  1  one-cycle pulse: current target split the transaction
- init0_grant  out  1  bus granted to initiator 0
- init1_grant  out  1  bus granted to initiator 1
- split_grant  out  1  bus granted to split target
- owner  out  2  0 none, 1 init0, 2 init1, 3 split target
- split_pending  out  1  one split transaction outstanding
- split_owner  out  1  initiator parked on the outstanding split (0/1); valid when split_pending
- timeout  out  1  one-cycle pulse on forced release
- split_err  out  1  one-cycle pulse: split_ack received while a split already pending

## Operation
- States: IDLE, BUSY. All grant/status outputs registered.
- IDLE: arbitrate on sampled inputs; winner's grant and owner set at next edge, state -> BUSY, timeout counter cleared.
- Priority: split_req (only if split_pending) > initiators. split_req with split_pending=0 ignored.
- Initiator eligible if req=1 and not parked (parked = split_pending && split_owner==i).
- Both eligible: round-robin; pointer last_init records last granted initiator; the other wins. Reset last_init=1, so init0 wins first tie.
- BUSY release events (any one ends tenure; grants and owner drop to 0 at the sampling edge, state -> IDLE):
  - txn_done=1: normal completion; if owner=3, clear split_pending.
  - split_ack=1 with owner 1/2 and split_pending=0: set split_pending, split_owner=owner-1.
  - split_ack=1 with split_pending=1: release, no state change, pulse split_err.
  - split_ack with owner=3: treated as txn_done.
  - owner's req drops (abandon): release; if owner=3, split_pending kept.
  - counter reaches TIMEOUT_CYCLES: release, pulse timeout; if owner=3, clear split_pending.
- txn_done and split_ack same cycle: txn_done wins, no split recorded.
- Timeout counter width ceil(log2(TIMEOUT_CYCLES+1)), saturating, increments each BUSY cycle.
- While split pending, the non-parked initiator may win tenures normally.

## Timing
- Reset: all grants 0, owner 0, split_pending 0, split_owner 0, timeout 0, split_err 0, counter 0, last_init 1, state IDLE.
- Request latency: req high in IDLE cycle c -> grant high in cycle c+1.
- Release: event sampled at edge e -> grant low from e; next grant earliest one cycle later (one IDLE cycle between tenures minimum).
- Exactly one grant high at any time; owner consistent with grant every cycle.
- Timeout: grant high for exactly TIMEOUT_CYCLES cycles without release event -> grant drops, timeout pulses same cycle grant falls.
- split_pending set/cleared on the same edge the grant drops.
- Async reset mid-tenure: grants drop immediately, split state discarded.

## Test plan
- init0_req held, txn_done after 5 cycles -> init0_grant high 1 cycle after req, owner=1, low after done; split_pending stays 0.
- init0 and init1 request same cycle after reset, each completes -> grant order init0, init1, init0 (round-robin), one idle cycle between tenures.
- init0 granted, split_ack -> split_pending=1, split_owner=0; init0_req still high receives no grant; init1_req granted, completes; split_req -> split_grant, owner=3; txn_done -> split_pending=0, init0 regranted.
- split_pending=1 and split_req plus init1_req same IDLE cycle -> split_grant wins.
- TIMEOUT_CYCLES=8, init1 granted, no done -> grant low after 8 cycles, timeout pulse 1 cycle, owner=0.
- Split pending for init0, init1 tenure gets split_ack -> split_err pulse, split_owner remains 0; txn_done with split_ack same cycle -> no split recorded; rst_n low mid-tenure -> all outputs 0 immediately.
